lsu_dcache_responder: RTL and testbench
=======================================

# lsu_dcache_responder

Responder (cache side) of the load unit's data-cache request port. It accepts the split index/tag load request driven on the LSU's `req_port_o` and answers on its `req_port_i`, with grant, tag phase, kill handling, configurable response latency and a backing word memory. It stands in for a real D-cache slice in unit-level LSU simulation, and can serve as a scratchpad responder on the load port.

## Interface
Parameters:
- `MemWords`, 512: backing memory depth in XLEN-bit words; power of two.
- `RespLat`, 1: cycles from the accepted tag phase to `data_rvalid`; 1..15.

Ports:
- `clk_i`  in  1  clock; one clock.
- `rst_i`  in  1  reset; asynchronous and active-high.
- `req_port_i`  in  `ariane_pkg::dcache_req_i_t`  request from the load unit: `address_index`, `address_tag`, `data_req`, `data_we`, `data_be`, `data_size`, `kill_req`, `tag_valid`.
- `req_port_o`  out  `ariane_pkg::dcache_req_o_t`  response: `data_gnt`, `data_rvalid`, `data_rdata`.
- `stall_i`  in  1  backpressure; while high, `data_gnt` is suppressed.
- `bd_we_i`  in  1  backdoor write strobe used for preload.
- `bd_addr_i`  in  $clog2(MemWords)  backdoor word address.
- `bd_wdata_i`  in  riscv::XLEN  backdoor write data.
- `oob_o`  out  1  one-cycle pulse with `data_rvalid` when the physical address was outside memory.
- `load_cnt_o`  out  16  completed responses; wraps.
- `kill_cnt_o`  out  16  requests killed after grant; wraps.

## Operation
- FSM states: IDLE, WAIT_TAG, RESP_WAIT.
- IDLE: `data_gnt = data_req & ~data_we & ~stall_i`, combinational. On grant, latch `address_index` and go to WAIT_TAG. A request with `data_we=1` is never granted; it stays pending and has no other effect.
- WAIT_TAG:
  - `kill_req` high → IDLE, `kill_cnt_o`++, no response. This takes priority over `tag_valid` in the same cycle.
  - Else `tag_valid` high → form `paddr = {address_tag, latched index}`, load the latency counter with `RespLat-1`, go to RESP_WAIT.
  - Else hold in WAIT_TAG.
- RESP_WAIT:
  - `kill_req` high → IDLE, `kill_cnt_o`++, no response.
  - Else, when the counter reaches 0, assert `data_rvalid` for one cycle, `load_cnt_o`++, go to IDLE. Otherwise decrement the counter.
- Read data: word index `paddr[3 +: $clog2(MemWords)]` (XLEN=64). The full word is returned; `data_be` and `data_size` are ignored because the LSU aligns the data.
- Out of range: if `paddr >> 3` ≥ `MemWords`, then `data_rdata = 0` and `oob_o = 1` with `data_rvalid`.
- Only one request is outstanding at a time; `data_gnt` is 0 outside IDLE.
- Backdoor write takes effect at the clock edge. A read of the same word is sampled in the `data_rvalid` cycle, so a backdoor write on or before that edge is visible.
- `data_rdata` is 0 whenever `data_rvalid` is low.

## Timing
- Reset (async on assertion, release synchronous to `clk_i`): state IDLE; `data_gnt`=0, `data_rvalid`=0, `data_rdata`=0, `oob_o`=0, counters 0, latency counter 0. Memory contents are not reset.
- Minimum load: grant at cycle T, `tag_valid` at T+1, `data_rvalid` at T+1+`RespLat`.
- A new grant is possible in the cycle after `data_rvalid`, at the earliest T+2+`RespLat`.
- Killing a request does not return any data; the next grant is possible in the cycle after the kill.
- Reset mid-transaction drops the request: no `data_rvalid` and no count.
- Counters wrap from 16'hFFFF to 0.

## Structure
- Package `lsu_resp_pkg` holds the state enum `resp_state_e` and `CntWidth = 16`.
- Request/response structs come from `ariane_pkg`.
- Sub-module `lsu_resp_mem`: single-write, async-read word array with the backdoor port.
- FSM, latency counter and counters live in the top module.

## Test plan
- Preload word 5 = 64'hDEAD_BEEF_0000_0005. Request index 12'h028, tag 0, `tag_valid` at T+1, `RespLat`=1 → `data_rvalid` at T+2 with that data; `load_cnt_o`=1.
- Assert `kill_req` and `tag_valid` together in WAIT_TAG → no `data_rvalid`; `kill_cnt_o`=1; next request granted the following cycle.
- `stall_i`=1 for 3 cycles with `data_req` high → `data_gnt` low for those 3 cycles, then high in the cycle after `stall_i` falls.
- `RespLat`=4, kill in the 2nd RESP_WAIT cycle → no response; state returns to IDLE; `load_cnt_o` unchanged.
- Tag giving `paddr` = 0x1000 with `MemWords`=512 → `data_rvalid` with `data_rdata`=0 and `oob_o`=1.
- Assert reset during RESP_WAIT → all outputs 0 immediately; no response after release; counters 0.

Source files
------------

// File: rtl/lsu_dcache_responder_pkg.sv
// Shared types for the load-port D-cache responder: minimal XLEN and request/response
// struct definitions plus the responder's own state enum and counter width.
package riscv;
  localparam int XLEN = 64;
  typedef logic [XLEN-1:0] xlen_t;
endpackage

package ariane_pkg;
  localparam int DCACHE_INDEX_WIDTH = 12;
  localparam int DCACHE_TAG_WIDTH   = 44;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic                          data_req;
    logic                          data_we;
    logic [7:0]                    data_be;
    logic [1:0]                    data_size;
    logic                          kill_req;
    logic                          tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic          data_gnt;
    logic          data_rvalid;
    riscv::xlen_t  data_rdata;
  } dcache_req_o_t;
endpackage

package lsu_resp_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_TAG, RESP_WAIT} resp_state_e;
  localparam int CntWidth = 16;
  localparam int LatWidth = 4;
endpackage

// File: rtl/lsu_dcache_responder_if.sv
// Load-port bundle between the LSU (master) and the cache-side responder (slave).
interface lsu_dcache_responder_if;
  import ariane_pkg::*;

  dcache_req_i_t req_port_i;
  dcache_req_o_t req_port_o;

  modport master (output req_port_i, input  req_port_o);
  modport slave  (input  req_port_i, output req_port_o);
endinterface

// File: rtl/lsu_dcache_responder_mem.sv
// Backing word array: one synchronous write port (backdoor preload), one async read port.
module lsu_resp_mem #(
    parameter int Words = 512,
    parameter int Width = 64,
    localparam int AW   = $clog2(Words)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [Width-1:0] rdata_o
);
    logic [Width-1:0] mem [Words];

    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/lsu_dcache_responder.sv
// Cache-side responder for the LSU load port: grant, tag phase, kill, fixed response
// latency and a backing word memory.
module lsu_dcache_responder
  import ariane_pkg::*;
  import lsu_resp_pkg::*;
#(
    parameter int MemWords = 512,
    parameter int RespLat  = 1,
    localparam int AW      = $clog2(MemWords)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    lsu_dcache_responder_if.slave   req_port,
    input  logic                    stall_i,
    input  logic                    bd_we_i,
    input  logic [AW-1:0]           bd_addr_i,
    input  logic [riscv::XLEN-1:0]  bd_wdata_i,
    output logic                    oob_o,
    output logic [CntWidth-1:0]     load_cnt_o,
    output logic [CntWidth-1:0]     kill_cnt_o
);
    localparam int PaWidth = DCACHE_TAG_WIDTH + DCACHE_INDEX_WIDTH;
    localparam logic [LatWidth-1:0] LatInit = LatWidth'(RespLat - 1);

    dcache_req_i_t                 req;
    resp_state_e                   state;
    logic [DCACHE_INDEX_WIDTH-1:0] idx_q;
    logic [PaWidth-1:0]            paddr_q;
    logic [LatWidth-1:0]           lat_q;
    logic [CntWidth-1:0]           load_cnt_q, kill_cnt_q;
    logic                          gnt, rvalid, oob;
    logic [riscv::XLEN-1:0]        word;
    logic                          unused_bits;

    assign req = req_port.req_port_i;

    // Stores are never granted; they simply sit pending on the port.
    assign gnt    = (state == IDLE) & req.data_req & ~req.data_we & ~stall_i & ~rst_i;
    assign rvalid = (state == RESP_WAIT) & (lat_q == '0) & ~req.kill_req;
    assign oob    = |paddr_q[PaWidth-1:3+AW];

    lsu_resp_mem #(.Words(MemWords), .Width(riscv::XLEN)) u_mem (
        .clk_i   (clk_i),
        .we_i    (bd_we_i),
        .waddr_i (bd_addr_i),
        .wdata_i (bd_wdata_i),
        .raddr_i (paddr_q[3 +: AW]),
        .rdata_o (word)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            idx_q      <= '0;
            paddr_q    <= '0;
            lat_q      <= '0;
            load_cnt_q <= '0;
            kill_cnt_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt) begin
                        idx_q <= req.address_index;
                        state <= WAIT_TAG;
                    end
                end
                WAIT_TAG: begin
                    if (req.kill_req) begin
                        kill_cnt_q <= kill_cnt_q + CntWidth'(1);
                        state      <= IDLE;
                    end else if (req.tag_valid) begin
                        paddr_q <= {req.address_tag, idx_q};
                        lat_q   <= LatInit;
                        state   <= RESP_WAIT;
                    end
                end
                RESP_WAIT: begin
                    if (req.kill_req) begin
                        kill_cnt_q <= kill_cnt_q + CntWidth'(1);
                        state      <= IDLE;
                    end else if (lat_q == '0) begin
                        load_cnt_q <= load_cnt_q + CntWidth'(1);
                        state      <= IDLE;
                    end else begin
                        lat_q <= lat_q - LatWidth'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Byte enables and size are irrelevant: the LSU realigns the full word itself.
    assign unused_bits = ^{req.data_be, req.data_size, paddr_q[2:0]};

    always_comb begin
        req_port.req_port_o             = '0;
        req_port.req_port_o.data_gnt    = gnt;
        req_port.req_port_o.data_rvalid = rvalid;
        req_port.req_port_o.data_rdata  = (rvalid && !oob) ? word : '0;
    end

    assign oob_o      = rvalid & oob;
    assign load_cnt_o = load_cnt_q;
    assign kill_cnt_o = kill_cnt_q;
endmodule

// File: tb/tb_lsu_dcache_responder.sv
// Directed bench: instance a (RespLat=1) for grant/kill/stall/oob, instance b (RespLat=4)
// for kill in RESP_WAIT and reset mid-transaction.
module tb_lsu_dcache_responder;
    import ariane_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_a, stall_b;
    logic        bd_we;
    logic [8:0]  bd_addr;
    logic [63:0] bd_wdata;
    logic        oob_a, oob_b;
    logic [15:0] lc_a, kc_a, lc_b, kc_b;
    int          n_cmp = 0;
    int          n_err = 0;

    lsu_dcache_responder_if ifa ();
    lsu_dcache_responder_if ifb ();

    lsu_dcache_responder #(.MemWords(512), .RespLat(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .req_port(ifa.slave), .stall_i(stall_a),
        .bd_we_i(bd_we), .bd_addr_i(bd_addr), .bd_wdata_i(bd_wdata),
        .oob_o(oob_a), .load_cnt_o(lc_a), .kill_cnt_o(kc_a));

    lsu_dcache_responder #(.MemWords(512), .RespLat(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .req_port(ifb.slave), .stall_i(stall_b),
        .bd_we_i(bd_we), .bd_addr_i(bd_addr), .bd_wdata_i(bd_wdata),
        .oob_o(oob_b), .load_cnt_o(lc_b), .kill_cnt_o(kc_b));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall_a = 0; stall_b = 0;
        bd_we = 0; bd_addr = '0; bd_wdata = '0;
        ifa.req_port_i = '0;
        ifb.req_port_i = '0;
        #1;
        chk("rst_gnt",    64'(ifa.req_port_o.data_gnt), 0);
        chk("rst_rvalid", 64'(ifa.req_port_o.data_rvalid), 0);
        chk("rst_rdata",  ifa.req_port_o.data_rdata, 0);
        chk("rst_oob",    64'(oob_a), 0);
        chk("rst_cnts",   64'({lc_a, kc_a}), 0);

        // preload word 5 and word 6 into both memories
        bd_we = 1; bd_addr = 9'd5; bd_wdata = 64'hDEAD_BEEF_0000_0005;
        tick();
        bd_addr = 9'd6; bd_wdata = 64'h0123_4567_89AB_CDEF;
        tick();
        bd_we = 0; rst = 0;
        tick();

        // store request is never granted
        ifa.req_port_i.data_req = 1; ifa.req_port_i.data_we = 1;
        ifa.req_port_i.address_index = 12'h028;
        #1 chk("we_no_gnt", 64'(ifa.req_port_o.data_gnt), 0);
        tick();
        // basic load: grant T, tag T+1, rvalid T+2
        ifa.req_port_i.data_we = 0;
        #1 chk("ld_gnt", 64'(ifa.req_port_o.data_gnt), 1);
        tick();
        ifa.req_port_i.data_req = 0; ifa.req_port_i.tag_valid = 1;
        ifa.req_port_i.address_tag = '0;
        #1 chk("ld_tag_nogn", 64'(ifa.req_port_o.data_gnt), 0);
        chk("ld_tag_norv", 64'(ifa.req_port_o.data_rvalid), 0);
        tick();
        ifa.req_port_i.tag_valid = 0;
        #1 chk("ld_rvalid", 64'(ifa.req_port_o.data_rvalid), 1);
        chk("ld_rdata", ifa.req_port_o.data_rdata, 64'hDEAD_BEEF_0000_0005);
        chk("ld_oob", 64'(oob_a), 0);
        tick();
        #1 chk("ld_cnt", 64'(lc_a), 1);
        chk("ld_rdata_idle", ifa.req_port_o.data_rdata, 0);

        // kill together with tag_valid in WAIT_TAG
        ifa.req_port_i.data_req = 1; ifa.req_port_i.address_index = 12'h030;
        #1 chk("k_gnt", 64'(ifa.req_port_o.data_gnt), 1);
        tick();
        ifa.req_port_i.data_req = 0; ifa.req_port_i.kill_req = 1; ifa.req_port_i.tag_valid = 1;
        #1 chk("k_norv", 64'(ifa.req_port_o.data_rvalid), 0);
        tick();
        ifa.req_port_i.kill_req = 0; ifa.req_port_i.tag_valid = 0; ifa.req_port_i.data_req = 1;
        #1 chk("k_regnt", 64'(ifa.req_port_o.data_gnt), 1);
        chk("k_norv2", 64'(ifa.req_port_o.data_rvalid), 0);
        chk("k_cnt", 64'(kc_a), 1);
        tick();
        // backdoor write on the edge entering the rvalid cycle is visible
        ifa.req_port_i.data_req = 0; ifa.req_port_i.tag_valid = 1;
        bd_we = 1; bd_addr = 9'd6; bd_wdata = 64'hCAFE_F00D_1234_0006;
        tick();
        bd_we = 0; ifa.req_port_i.tag_valid = 0;
        #1 chk("bd_rvalid", 64'(ifa.req_port_o.data_rvalid), 1);
        chk("bd_rdata", ifa.req_port_o.data_rdata, 64'hCAFE_F00D_1234_0006);
        tick();
        #1 chk("bd_cnt", 64'(lc_a), 2);

        // stall suppresses grant for 3 cycles
        stall_a = 1; ifa.req_port_i.data_req = 1; ifa.req_port_i.address_index = 12'h000;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("stall_%0d", i), 64'(ifa.req_port_o.data_gnt), 0);
            tick();
        end
        stall_a = 0;
        #1 chk("stall_rel_gnt", 64'(ifa.req_port_o.data_gnt), 1);
        tick();
        // paddr = 0x1000 is beyond 512 words
        ifa.req_port_i.data_req = 0; ifa.req_port_i.tag_valid = 1;
        ifa.req_port_i.address_tag = 44'd1;
        tick();
        ifa.req_port_i.tag_valid = 0;
        #1 chk("oob_rvalid", 64'(ifa.req_port_o.data_rvalid), 1);
        chk("oob_rdata", ifa.req_port_o.data_rdata, 0);
        chk("oob_flag", 64'(oob_a), 1);
        tick();
        #1 chk("oob_cnt", 64'(lc_a), 3);
        chk("oob_clr", 64'(oob_a), 0);

        // RespLat=4: kill in 2nd RESP_WAIT cycle
        ifb.req_port_i.data_req = 1; ifb.req_port_i.address_index = 12'h028;
        #1 chk("b_gnt", 64'(ifb.req_port_o.data_gnt), 1);
        tick();
        ifb.req_port_i.data_req = 0; ifb.req_port_i.tag_valid = 1;
        tick();
        ifb.req_port_i.tag_valid = 0;
        #1 chk("b_rw1", 64'(ifb.req_port_o.data_rvalid), 0);
        tick();
        ifb.req_port_i.kill_req = 1;
        #1 chk("b_rw2_kill", 64'(ifb.req_port_o.data_rvalid), 0);
        tick();
        ifb.req_port_i.kill_req = 0; ifb.req_port_i.data_req = 1;
        #1 chk("b_kill_idle", 64'(ifb.req_port_o.data_gnt), 1);
        chk("b_kcnt", 64'(kc_b), 1);
        chk("b_lcnt0", 64'(lc_b), 0);
        tick();
        ifb.req_port_i.data_req = 0; ifb.req_port_i.tag_valid = 1;
        tick();
        ifb.req_port_i.tag_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("b_wait_%0d", i), 64'(ifb.req_port_o.data_rvalid), 0);
            tick();
        end
        #1 chk("b_rvalid", 64'(ifb.req_port_o.data_rvalid), 1);
        chk("b_rdata", ifb.req_port_o.data_rdata, 64'hDEAD_BEEF_0000_0005);
        tick();
        #1 chk("b_lcnt1", 64'(lc_b), 1);

        // reset during RESP_WAIT drops the request
        ifb.req_port_i.data_req = 1;
        tick();
        ifb.req_port_i.data_req = 0; ifb.req_port_i.tag_valid = 1;
        tick();
        ifb.req_port_i.tag_valid = 0; ifb.req_port_i.data_req = 1;
        #1 rst = 1;
        #1 chk("mr_gnt", 64'(ifb.req_port_o.data_gnt), 0);
        chk("mr_rvalid", 64'(ifb.req_port_o.data_rvalid), 0);
        chk("mr_cnts", 64'({lc_b, kc_b}), 0);
        tick();
        rst = 0; ifb.req_port_i.data_req = 0;
        for (int i = 0; i < 6; i++) begin
            #1 chk($sformatf("mr_norv_%0d", i), 64'(ifb.req_port_o.data_rvalid), 0);
            tick();
        end
        #1 chk("mr_cnts_after", 64'({lc_b, kc_b}), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
